// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data Memory block: one byte/half/word request at a time,
// sub-word stores done as read-modify-write, one-cycle response with extended load data.
module lsu_mem_master (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr[0];
            SZ_WORD: err = (addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        return err | (addr[31:12] != 20'd0);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the read word with the low store bits
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) begin
                    r[31:16] = wdata;
                end else begin
                    r[15:0] = wdata;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    state_t      state_r, next_s;
    logic        we_r, uns_r;
    logic [1:0]  size_r;
    logic [11:0] addr_r;
    logic [15:0] wdata_r;

    logic        accept_s;
    logic [11:0] op_addr_s;
    logic [31:0] addr_next_s, din_next_s, rdata_next_s;
    logic        err_next_s;

    logic        ren_r, wen_r, rvalid_r, rerr_r;
    logic [31:0] maddr_r, din_r, rdata_r;

    assign req_ready = (state_r == ST_IDLE) && !reset;
    assign accept_s  = req_valid && req_ready;
    assign op_addr_s = (state_r == ST_IDLE) ? req_addr[11:0] : addr_r;

    // Next state plus the values the output registers take on entering that state
    always_comb begin
        next_s       = state_r;
        din_next_s   = 32'd0;
        rdata_next_s = 32'd0;
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    next_s = ST_IDLE;
                end else if (req_error(req_size, req_addr)) begin
                    next_s     = ST_RESP;
                    err_next_s = 1'b1;
                end else if (!req_we) begin
                    next_s = ST_RD;
                end else if (req_size == SZ_WORD) begin
                    next_s     = ST_WR;
                    din_next_s = req_wdata;
                end else begin
                    next_s = ST_RD;
                end
            end
            ST_RD: begin
                if (we_r) begin
                    next_s     = ST_WR;
                    din_next_s = store_merge(mem_dout, wdata_r, size_r, addr_r[1:0]);
                end else begin
                    next_s       = ST_RESP;
                    rdata_next_s = load_extend(mem_dout, size_r, uns_r, addr_r[1:0]);
                end
            end
            ST_WR:   next_s = ST_RESP;
            ST_RESP: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
        if ((next_s == ST_RD) || (next_s == ST_WR)) begin
            addr_next_s = {22'd0, op_addr_s[11:2]};
        end else begin
            addr_next_s = 32'd0;
        end
    end

    // State, request latch and registered outputs; reset kills any in-flight access at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            we_r     <= 1'b0;
            uns_r    <= 1'b0;
            size_r   <= 2'b00;
            addr_r   <= 12'd0;
            wdata_r  <= 16'd0;
            ren_r    <= 1'b0;
            wen_r    <= 1'b0;
            maddr_r  <= 32'd0;
            din_r    <= 32'd0;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            rerr_r   <= 1'b0;
        end else begin
            state_r <= next_s;
            if (accept_s) begin
                we_r    <= req_we;
                uns_r   <= req_unsigned;
                size_r  <= req_size;
                addr_r  <= req_addr[11:0];
                wdata_r <= req_wdata[15:0];
            end
            ren_r    <= (next_s == ST_RD);
            wen_r    <= (next_s == ST_WR);
            maddr_r  <= addr_next_s;
            din_r    <= din_next_s;
            rvalid_r <= (next_s == ST_RESP);
            rdata_r  <= rdata_next_s;
            rerr_r   <= err_next_s;
        end
    end

    assign mem_ren    = ren_r;
    assign mem_wen    = wen_r;
    assign mem_addr   = maddr_r;
    assign mem_din    = din_r;
    assign resp_valid = rvalid_r;
    assign resp_rdata = rdata_r;
    assign resp_err   = rerr_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a byte-array reference model,
// with a word-array Memory model attached to the mem_* port.
module tb_lsu_mem_master;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_cmp = 0;
    int n_mis = 0;
    int viol  = 0;

    logic [31:0] mem_w [0:1023];
    logic [7:0]  ref_b [0:4095];

    lsu_mem_master dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    // Memory block: combinational read, write commits on the negedge
    assign mem_dout = (mem_ren && !mem_wen) ? mem_w[mem_addr[9:0]] : 32'd0;
    always @(negedge clock) begin
        if (mem_wen) mem_w[mem_addr[9:0]] <= mem_din;
    end

    // Idle-output and ren/wen exclusivity monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_ren && mem_wen) viol++;
            if (!mem_ren && !mem_wen && mem_addr != 32'd0) viol++;
            if (!mem_wen && mem_din != 32'd0) viol++;
            if (!resp_valid && (resp_rdata != 32'd0 || resp_err)) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata_o);
        int n, w, lat, rd_n, wr_n, rd_at, wr_at, bad;
        int exp_lat, exp_rd_at, exp_wr_at;
        logic e, got, got_err;
        logic [31:0] v, base, exp_rdata, exp_din, exp_idx, got_rdata, got_din;

        n = 1 << size;
        e = (size == 2'd3) || (addr > 32'h0000_0FFF) || ((addr & (n - 1)) != 0);
        exp_idx = addr / 4;
        exp_rdata = 32'd0; exp_din = 32'd0;
        exp_rd_at = 0; exp_wr_at = 0; exp_lat = 1;
        if (!e) begin
            if (!we) begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_b[addr + i]) << (8 * i));
                if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                exp_rdata = v; exp_rd_at = 1; exp_lat = 2;
            end else begin
                for (int i = 0; i < n; i++) ref_b[addr + i] = 8'(wdata >> (8 * i));
                base = addr & 32'hFFFF_FFFC;
                for (int i = 0; i < 4; i++) exp_din = exp_din | (32'(ref_b[base + i]) << (8 * i));
                if (n == 4) begin
                    exp_wr_at = 1; exp_lat = 2;
                end else begin
                    exp_rd_at = 1; exp_wr_at = 2; exp_lat = 3;
                end
            end
        end

        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clock);
            w++;
        end
        check("ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

        got = 1'b0; lat = 0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0; bad = 0;
        got_rdata = 32'd0; got_err = 1'b0; got_din = 32'd0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clock);
            if (mem_ren) begin rd_n++; rd_at = c; if (mem_addr != exp_idx) bad++; end
            if (mem_wen) begin wr_n++; wr_at = c; got_din = mem_din; if (mem_addr != exp_idx) bad++; end
            if (resp_valid) begin got = 1'b1; lat = c; got_rdata = resp_rdata; got_err = resp_err; end
        end
        check("resp_seen", {31'd0, got}, 32'd1);
        check("latency", lat, exp_lat);
        check("resp_err", {31'd0, got_err}, {31'd0, e});
        check("resp_rdata", got_rdata, exp_rdata);
        check("rd_cycles", rd_n, (exp_rd_at != 0) ? 1 : 0);
        check("wr_cycles", wr_n, (exp_wr_at != 0) ? 1 : 0);
        check("rd_at", rd_at, exp_rd_at);
        check("wr_at", wr_at, exp_wr_at);
        check("mem_addr", bad, 0);
        if (exp_wr_at != 0) check("mem_din", got_din, exp_din);
        rdata_o = got_rdata;
    endtask

    logic [31:0] r;
    logic [31:0] a;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_w[i] = $urandom;
            for (int k = 0; k < 4; k++) ref_b[4 * i + k] = 8'(mem_w[i] >> (8 * k));
        end
        mem_w[4] = 32'h8070_F0A5;
        ref_b[16] = 8'hA5; ref_b[17] = 8'hF0; ref_b[18] = 8'h70; ref_b[19] = 8'h80;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_outs", {31'd0, mem_ren | mem_wen | resp_valid | resp_err | (|mem_addr)
                                  | (|mem_din) | (|resp_rdata)}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_ready", {31'd0, req_ready}, 32'd1);

        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, r); check("lb_10", r, 32'hFFFF_FFA5);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, r); check("lbu_11", r, 32'h0000_00F0);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, r); check("lh_12", r, 32'hFFFF_8070);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, r); check("lhu_12", r, 32'h0000_8070);
        do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, r); check("lh_10", r, 32'hFFFF_F0A5);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h11, r);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r); check("lw_after_sb", r, 32'h1170_F0A5);
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, r);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, r); check("lw_20", r, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, r);
        do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, r);
        do_req(1'b0, 2'd3, 1'b0, 32'h14, 32'd0, r);

        // restore word 4 for the mid-WR reset scenario
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h8070_F0A5, r);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h1234_5678;
        for (int c = 0; c < 10 && !req_ready; c++) @(negedge clock);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        #1;
        check("midwr_wen_pre", {31'd0, mem_wen}, 32'd1);
        reset = 1'b1;
        #1;
        check("midwr_wen_drop", {31'd0, mem_wen}, 32'd0);
        check("midwr_outs", {31'd0, mem_ren | resp_valid | resp_err | req_ready | (|mem_addr)
                                    | (|mem_din) | (|resp_rdata)}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("postrst_ready", {31'd0, req_ready}, 32'd1);
        check("postrst_word4", mem_w[4], 32'h8070_F0A5);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, r); check("postrst_lw", r, 32'h8070_F0A5);

        for (int t = 0; t < 80; t++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, r);
        end

        check("idle_outputs", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that drives the data `Memory` block's `ren`/`wen`/`addr`/`din`/`dout` port on behalf of the processor datapath. It accepts one byte, halfword or word request at a time through a valid/ready handshake. It performs the memory read, write, or read-modify-write, and returns a one-cycle response with sign/zero-extended load data or an error flag. It sits between the EX/MEM stage and the `Memory` instance.

## Interface
- No parameters; data and address width fixed at 32.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE with reset deasserted; request is accepted on a posedge where `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle pulse; no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: valid with `resp_valid`.
- `mem_ren` out 1: to `Memory.ren`.
- `mem_wen` out 1: to `Memory.wen`.
- `mem_addr` out 32: to `Memory.addr`; word index `{22'b0, addr[11:2]}`.
- `mem_din` out 32: to `Memory.din`.
- `mem_dout` in 32: from `Memory.dout`; combinational when `ren=1`, `wen=0`.

## Operation
- **Request latching.** On acceptance, latch `we`, `size`, `unsigned`, `addr` and `wdata`. Later changes on `req_*` are ignored until the next acceptance.
- **States:**
  - IDLE: no memory operation in progress; `req_ready` high.
  - RD: `mem_ren`=1. At the end-of-cycle posedge, capture `mem_dout` into the word register.
  - WR: `mem_wen`=1, `mem_din` = write word. `Memory` commits on the negedge inside this cycle.
  - RESP: `resp_valid`=1 for one cycle.
- **Transitions out of IDLE on acceptance:**
  - Error → RESP.
  - Load → RD.
  - Word store → WR.
  - Byte/half store → RD.
- **Other transitions:**
  - RD → RESP for a load, or RD → WR for a sub-word store.
  - WR → RESP.
  - RESP → IDLE unconditionally.
- **Error conditions:**
  - `req_size`=11.
  - Half with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr[31:12]`≠0.
  - On error: no `mem_ren`/`mem_wen` pulse, `resp_err`=1, `resp_rdata`=0.
- **Byte lanes (little-endian).**
  - Byte at offset k occupies word bits [8k+7:8k].
  - Half at offset 0 occupies [15:0]; at offset 2 it occupies [31:16].
- **Load data.** Extract the lane and extend to 32 bits per `req_unsigned`.
- **Sub-word store.** Write word = read word with only the target lane replaced by the low byte/half of `wdata`.
- **Idle outputs.** `mem_ren` and `mem_wen` are never both 1. Outside RD/WR both are 0. `mem_addr` is the latched word index in RD/WR, else 0. `mem_din` is 0 outside WR.

## Timing
- **Reset values:** state IDLE; `req_ready`=0 while `reset` is high; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; `mem_ren`=0, `mem_wen`=0, `mem_addr`=0, `mem_din`=0.
- **Reset mid-operation.** Reset asserted in any state drops `mem_wen`/`mem_ren` immediately (asynchronously). No write commits after reset assertion, and no response is issued. `req_ready` rises on reset deassertion.
- **Latency from the acceptance edge T:**
  - Error: `resp_valid` high in cycle T+1.
  - Load: RD in cycle T+1, `resp_valid` in T+2.
  - Word store: WR in T+1, `resp_valid` in T+2.
  - Sub-word store: RD in T+1, WR in T+2, `resp_valid` in T+3.
- **Throughput.** Next acceptance is possible at the first posedge after RESP.
- **Load data hold.** `resp_rdata` and `resp_err` are registered and hold for the RESP cycle only; they return to 0 in IDLE.

## Test plan
Preload word 4 (byte address 0x10) = 0x8070F0A5 for all scenarios.
- **Byte loads.**
  - lb 0x10 → `resp_rdata`=0xFFFFFFA5, `resp_valid` exactly 2 cycles after acceptance, `mem_addr`=4 during RD.
  - lbu 0x11 → 0x000000F0.
- **Halfword loads.**
  - lh 0x12 → 0xFFFF8070.
  - lhu 0x12 → 0x00008070.
  - lh 0x10 → 0xFFFFF0A5.
- **Byte store (read-modify-write).**
  - sb 0x13 with `wdata`=0x00000011 → sequence RD, WR, RESP.
  - `mem_din`=0x1170F0A5; a following lw 0x10 returns 0x1170F0A5.
  - `mem_ren & mem_wen` never 1.
- **Word store.**
  - sw 0x20 with 0xDEADBEEF → single WR cycle with `mem_addr`=8, `mem_din`=0xDEADBEEF; no RD cycle.
  - lw 0x20 then returns 0xDEADBEEF.
- **Errors.** Each of the following gives `resp_err`=1, `resp_rdata`=0, response at T+1, and no `mem_ren`/`mem_wen` activity:
  - lh 0x11.
  - lw 0x1000.
  - size=11.
- **Reset mid-operation.**
  - Assert `reset` mid-WR of sw 0x10 with 0x12345678 → `mem_wen` falls immediately, all outputs 0, word 4 still 0x8070F0A5.
  - After release, `req_ready`=1 and a new lw completes normally.
